mux4_rr_arbiter: RTL



---
 rtl/mux4_rr_arbiter_pkg.sv | 5 +
 rtl/mux4_rr_arbiter_pick.sv | 17 +
 rtl/mux4_rr_arbiter.sv | 73 +++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_arb_defs: shared state encodings and requester count for the mux4 round-robin arbiter
package mux4_arb_defs;
  localparam int NREQ = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_e;
endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// rr_pick4: rotate-priority encoder, first set request scanning from ptr upward modulo 4
module rr_pick4
  import mux4_arb_defs::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            found,
  output logic [1:0]      idx
);
  logic [NREQ-1:0] rot;
  logic [1:0]      off;
  // Bit k of rot is the request of requester ptr+k
  assign rot   = NREQ'({req, req} >> ptr);
  assign off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign found = |rot;
  assign idx   = ptr + off;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant/select sequencer with bounded tenure and a one-cycle changeover gap
module mux4_rr_arbiter
  import mux4_arb_defs::*;
#(
  parameter int HOLD_W = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            sel_valid,
  output logic            busy
);
  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d, sel_q, sel_d, pick_idx;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic                pick_found;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    if (state_q == GRANT) begin
      // Owner leaves on its own release or when tenure is exhausted
      if (!req[sel_q] || cnt_q == {HOLD_W{1'b1}}) begin
        state_d = GAP;
        ptr_d   = sel_q + 2'd1;
        gnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pick_found) begin
      state_d = GRANT;
      gnt_d   = NREQ'(1) << pick_idx;
      sel_d   = pick_idx;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign sel_valid = (state_q == GRANT);
  assign busy      = (state_q != IDLE);
endmodule
